gf_mult_iter: RTL



---
 rtl/gf_pkg.sv | 13 +
 rtl/gf_xtime.sv | 14 +
 rtl/gf_mult_iter.sv | 87 ++++++++
 3 files changed

// File: rtl/gf_pkg.sv
// Shared constants and state encoding for the iterative AES-field GF(2^8) multiplier.
package gf_pkg;

  localparam int         GF_WIDTH = 8;
  localparam logic [7:0] GF_POLY  = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_state_t;

endpackage

// File: rtl/gf_xtime.sv
// Combinational multiply-by-x in GF(2^8): shift left, fold the dropped x^8 term back in via POLY.
module gf_xtime
  import gf_pkg::*;
#(
  parameter int               WIDTH = GF_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = GF_POLY
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = {a[WIDTH-2:0], 1'b0} ^ (a[WIDTH-1] ? POLY : {WIDTH{1'b0}});

endmodule

// File: rtl/gf_mult_iter.sv
// Iterative shift-and-add GF(2^8) multiplier, one multiplier bit per RUN cycle, valid/ready on both sides.
module gf_mult_iter
  import gf_pkg::*;
#(
  parameter int               WIDTH = GF_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = GF_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  gf_state_t        state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic [2:0]       count;
  logic [WIDTH-1:0] a_x;
  logic [WIDTH-1:0] acc_next;

  gf_xtime #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_xtime (
    .a (a),
    .y (a_x)
  );

  assign acc_next = acc ^ (b[0] ? a : {WIDTH{1'b0}});

  // Fixed 8-cycle run: no early exit, so latency never depends on the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a        <= in1;
            b        <= in2;
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a     <= a_x;
          b     <= b >> 1;
          acc   <= acc_next;
          count <= count + 3'd1;
          if (count == 3'd7) begin
            out       <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
